// File: rtl/vdp_cpu_port.sv
// Z80-side VDP port: two-byte control word, VRAM/CRAM/register writes,
// VRAM read-ahead buffer and status reads.
//
// state      | meaning
// IDLE       | accepting CPU strobes
// PF_ISSUE   | vram_re driven at the read-ahead address
// PF_CAPTURE | vram_rdata captured into rbuf, addr advanced
module vdp_cpu_port (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        port_sel,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        port_busy,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  cram_addr,
    output logic [5:0]  cram_wdata,
    output logic        cram_we,
    output logic        reg_we,
    output logic [3:0]  reg_num,
    output logic [7:0]  reg_data,
    input  logic [7:0]  status_in,
    output logic        status_clr
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PF_ISSUE   = 2'd1,
        PF_CAPTURE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [13:0] addr;
    logic [1:0]  code;
    logic [7:0]  latch;
    logic        second;
    logic [7:0]  rbuf;

    logic take_wr, take_rd, ctrl_second, pf_start;

    // Strobes arriving during a read-ahead are dropped; a write wins over a read.
    assign take_wr     = (state == IDLE) && cpu_wr;
    assign take_rd     = (state == IDLE) && cpu_rd && !cpu_wr;
    assign ctrl_second = take_wr && port_sel && second;
    assign pf_start    = (ctrl_second && (cpu_din[7:6] == 2'b00)) || (take_rd && !port_sel);

    assign port_busy = (state != IDLE);
    assign vram_re   = (state == PF_ISSUE);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (pf_start) state_nxt = PF_ISSUE;
            PF_ISSUE:   state_nxt = PF_CAPTURE;
            PF_CAPTURE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            addr       <= '0;
            code       <= '0;
            latch      <= '0;
            second     <= 1'b0;
            rbuf       <= '0;
            cpu_dout   <= '0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_we    <= 1'b0;
            cram_addr  <= '0;
            cram_wdata <= '0;
            cram_we    <= 1'b0;
            reg_we     <= 1'b0;
            reg_num    <= '0;
            reg_data   <= '0;
            status_clr <= 1'b0;
        end else begin
            vram_we    <= 1'b0;
            cram_we    <= 1'b0;
            reg_we     <= 1'b0;
            status_clr <= 1'b0;

            if (take_wr && port_sel) begin
                if (!second) begin
                    latch      <= cpu_din;
                    addr[7:0]  <= cpu_din;
                    second     <= 1'b1;
                end else begin
                    code   <= cpu_din[7:6];
                    addr   <= {cpu_din[5:0], latch};
                    second <= 1'b0;
                    if (cpu_din[7:6] == 2'b10) begin
                        reg_we   <= 1'b1;
                        reg_num  <= cpu_din[3:0];
                        reg_data <= latch;
                    end
                    if (cpu_din[7:6] == 2'b00)
                        vram_addr <= {cpu_din[5:0], latch};
                end
            end else if (take_wr) begin
                second <= 1'b0;
                rbuf   <= cpu_din;
                addr   <= addr + 14'd1;
                if (code == 2'b11) begin
                    cram_we    <= 1'b1;
                    cram_addr  <= addr[4:0];
                    cram_wdata <= cpu_din[5:0];
                end else begin
                    vram_we    <= 1'b1;
                    vram_addr  <= addr;
                    vram_wdata <= cpu_din;
                end
            end else if (take_rd) begin
                second <= 1'b0;
                if (port_sel) begin
                    cpu_dout   <= status_in;
                    status_clr <= 1'b1;
                end else begin
                    cpu_dout  <= rbuf;
                    vram_addr <= addr;
                end
            end

            if (state == PF_CAPTURE) begin
                rbuf <= vram_rdata;
                addr <= addr + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        cpu_wr, cpu_rd, port_sel;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        port_busy;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we, vram_re;
    logic [7:0]  vram_rdata;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_wdata;
    logic        cram_we, reg_we;
    logic [3:0]  reg_num;
    logic [7:0]  reg_data;
    logic [7:0]  status_in;
    logic        status_clr;

    vdp_cpu_port dut (
        .clk(clk), .rst_L(rst_L), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .port_busy(port_busy), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata), .cram_we(cram_we),
        .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data),
        .status_in(status_in), .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    localparam int EV_DOUT = 0, EV_VWR = 1, EV_CWR = 2, EV_REG = 3, EV_VRE = 4, EV_STC = 5;

    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    logic [7:0] vmem [0:16383];
    logic       rd_q;

    always @(posedge clk) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        if (vram_re) vram_rdata <= vmem[vram_addr];
    end

    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) rd_q <= 1'b0;
        else        rd_q <= cpu_rd && !cpu_wr;
    end

    function automatic string kname(input int k);
        case (k)
            EV_DOUT: return "dout";
            EV_VWR:  return "vram_wr";
            EV_CWR:  return "cram_wr";
            EV_REG:  return "reg_wr";
            EV_VRE:  return "vram_rd";
            default: return "status_clr";
        endcase
    endfunction

    task automatic push(input int k, input logic [13:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int k, input logic [13:0] a, input logic [7:0] d);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s: got addr=%h data=%h, required no event", kname(k), a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.addr != a || e.data != d) begin
                miscompares++;
                $display("FAIL %s: got %s addr=%h data=%h, required %s addr=%h data=%h",
                         kname(e.kind), kname(k), a, d, kname(e.kind), e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_L) begin
            if (rd_q)       observe(EV_DOUT, 14'd0, cpu_dout);
            if (vram_we)    observe(EV_VWR, vram_addr, vram_wdata);
            if (cram_we)    observe(EV_CWR, {9'd0, cram_addr}, {2'b00, cram_wdata});
            if (reg_we)     observe(EV_REG, {10'd0, reg_num}, reg_data);
            if (vram_re)    observe(EV_VRE, vram_addr, 8'd0);
            if (status_clr) observe(EV_STC, 14'd0, 8'd0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called at a negedge; holds the strobe for exactly one rising edge.
    task automatic strobe(input logic w, input logic s, input logic [7:0] d);
        cpu_wr = w; cpu_rd = !w; port_sel = s; cpu_din = d;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
        vmem[14'h0100] = 8'h11;
        vmem[14'h0101] = 8'h22;
        vmem[14'h0103] = 8'h33;
        rst_L = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; port_sel = 1'b0;
        cpu_din = 8'h00; status_in = 8'h00;
        idle(3);
        check("reset_outputs",
              {cpu_dout, port_busy, vram_addr, vram_wdata, vram_we, vram_re, cram_addr,
               cram_wdata, cram_we, reg_we, reg_num, reg_data, status_clr}, 64'd0);
        rst_L = 1'b1;
        idle(2);

        // VRAM write setup at 0x0234, two writes back-to-back
        strobe(1, 1, 8'h34); strobe(1, 1, 8'h42);
        push(EV_VWR, 14'h0234, 8'hAA); strobe(1, 0, 8'hAA);
        push(EV_VWR, 14'h0235, 8'hBB); strobe(1, 0, 8'hBB);
        idle(2);

        // register 1 <= 0x05
        push(EV_REG, 14'd1, 8'h05);
        strobe(1, 1, 8'h05); strobe(1, 1, 8'h81);
        idle(2);

        // CRAM 0x1F then wrap to 0x00
        strobe(1, 1, 8'h1F); strobe(1, 1, 8'hC0);
        push(EV_CWR, 14'h001F, 8'h3F); strobe(1, 0, 8'h3F);
        push(EV_CWR, 14'h0000, 8'h15); strobe(1, 0, 8'h15);
        idle(2);

        // read setup at 0x0100 and busy window
        push(EV_VRE, 14'h0100, 8'h00);
        strobe(1, 1, 8'h00); strobe(1, 1, 8'h01);
        check("busy_n1", port_busy, 1);
        idle(1);
        check("busy_n2", port_busy, 1);
        idle(1);
        check("busy_n3", port_busy, 0);
        push(EV_DOUT, 14'd0, 8'h11); push(EV_VRE, 14'h0101, 8'h00);
        strobe(0, 0, 8'h00); idle(3);
        push(EV_DOUT, 14'd0, 8'h22); push(EV_VRE, 14'h0102, 8'h00);
        strobe(0, 0, 8'h00); idle(3);

        // address wrap 3FFF -> 0000
        strobe(1, 1, 8'hFF); strobe(1, 1, 8'h7F);
        push(EV_VWR, 14'h3FFF, 8'h5A); strobe(1, 0, 8'h5A);
        push(EV_VWR, 14'h0000, 8'hA5); strobe(1, 0, 8'hA5);
        idle(2);

        // status read clears the half-written control word
        strobe(1, 1, 8'h12);
        status_in = 8'h80;
        push(EV_DOUT, 14'd0, 8'h80); push(EV_STC, 14'd0, 8'h00);
        strobe(0, 1, 8'h00);
        strobe(1, 1, 8'h50); strobe(1, 1, 8'h42);
        push(EV_VWR, 14'h0250, 8'h77); strobe(1, 0, 8'h77);
        idle(2);

        // write during busy is dropped (no VRAM write, rbuf untouched)
        push(EV_VRE, 14'h0100, 8'h00);
        strobe(1, 1, 8'h00); strobe(1, 1, 8'h01);
        strobe(1, 0, 8'h99);
        idle(3);
        push(EV_DOUT, 14'd0, 8'h11); push(EV_VRE, 14'h0101, 8'h00);
        strobe(0, 0, 8'h00); idle(3);

        // simultaneous write and read: only the write happens
        push(EV_VWR, 14'h0102, 8'h3C);
        cpu_wr = 1'b1; cpu_rd = 1'b1; port_sel = 1'b0; cpu_din = 8'h3C;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        idle(2);
        push(EV_DOUT, 14'd0, 8'h3C); push(EV_VRE, 14'h0103, 8'h00);
        strobe(0, 0, 8'h00); idle(3);

        // reset during a read-ahead
        push(EV_DOUT, 14'd0, 8'h33); push(EV_VRE, 14'h0104, 8'h00);
        strobe(0, 0, 8'h00);
        #1 rst_L = 1'b0;
        #2 rst_L = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", port_busy, 0);
        check("rst_mid_re", vram_re, 0);
        check("rst_mid_dout", cpu_dout, 0);
        idle(2);
        push(EV_DOUT, 14'd0, 8'h00); push(EV_VRE, 14'h0000, 8'h00);
        strobe(0, 0, 8'h00); idle(4);

        check("events_outstanding", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-facing control/data port of the VDP: decodes Z80 accesses to the VDP control and data ports and writes into the same VRAM, CRAM and VDP register file that the display interface reads during scan-out. It implements the two-byte control word sequence, address auto-increment, the one-byte VRAM read-ahead buffer, and status reads. It sits between the Z80 bus decoder and the A-side ports of the VRAM/CRAM `mem` instances and the register bank.

## Interface
- No parameters; widths fixed by the VDP memory map (VRAM 16 KB, CRAM 32 x 6 bit, 16 registers).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_L`  in  1  asynchronous, active-low reset.
- `cpu_wr`  in  1  one-cycle write strobe.
- `cpu_rd`  in  1  one-cycle read strobe.
- `port_sel`  in  1  0 = data port, 1 = control port.
- `cpu_din`  in  8  write data from CPU.
- `cpu_dout`  out  8  read data to CPU (registered, held until next read).
- `port_busy`  out  1  high while a VRAM read-ahead is in flight.
- `vram_addr`  out  14  VRAM A-port address.
- `vram_wdata`  out  8  VRAM write data.
- `vram_we`  out  1  VRAM write enable (one-cycle pulse).
- `vram_re`  out  1  VRAM read enable (one-cycle pulse).
- `vram_rdata`  in  8  VRAM read data, valid one cycle after `vram_re`.
- `cram_addr`  out  5  CRAM address.
- `cram_wdata`  out  6  CRAM write data (`cpu_din[5:0]`).
- `cram_we`  out  1  CRAM write enable (one-cycle pulse).
- `reg_we`  out  1  register-file write pulse.
- `reg_num`  out  4  register index.
- `reg_data`  out  8  register write data.
- `status_in`  in  8  VDP status byte.
- `status_clr`  out  1  one-cycle pulse: status flags consumed.

## Operation
- Internal state: `addr[13:0]`, `code[1:0]`, `latch[7:0]`, `second` flag, `rbuf[7:0]`, FSM {IDLE, PF_ISSUE, PF_CAPTURE}.
- Reset: all outputs 0, `addr`=0, `code`=0, `second`=0, `rbuf`=0, FSM=IDLE.
- Control write, `second`=0: `latch`<=`cpu_din`, `addr[7:0]`<=`cpu_din`, `second`<=1.
- Control write, `second`=1: `code`<=`cpu_din[7:6]`, `addr`<={`cpu_din[5:0]`,`latch`}, `second`<=0; then by code:
  - 0: VRAM read setup -> start read-ahead.
  - 1: VRAM write setup, no memory access.
  - 2: register write: `reg_num`=`cpu_din[3:0]`, `reg_data`=`latch`, `reg_we` pulse.
  - 3: CRAM write setup.
- Data write: `second`<=0; code 3 -> CRAM write at `addr[4:0]`; codes 0,1,2 -> VRAM write at `addr`. `rbuf`<=`cpu_din` in all cases. `addr`<=`addr`+1.
- Data read: `cpu_dout`<=`rbuf`, `second`<=0, start read-ahead.
- Control read: `cpu_dout`<=`status_in`, `second`<=0, `status_clr` pulse.
- Read-ahead: PF_ISSUE drives `vram_re` with `vram_addr`=`addr`; PF_CAPTURE loads `rbuf`<=`vram_rdata`, `addr`<=`addr`+1; back to IDLE.
- `addr` increments modulo 2^14 (3FFF -> 0000); CRAM uses `addr[4:0]`, so CRAM wraps 1F -> 00.
- Strobes while `port_busy`=1 are ignored entirely (no state change).
- `cpu_wr` and `cpu_rd` same cycle: write taken, read ignored.
- Reset mid read-ahead: FSM to IDLE, no `vram_re`, `rbuf`=0.

## Timing
- Strobe sampled at edge N; all resulting pulses (`vram_we`, `cram_we`, `reg_we`, `status_clr`) high for exactly cycle N+1; `cpu_dout` valid from N+1.
- Address/data outputs stable during their enable pulse.
- Read-ahead: `vram_re` and `port_busy` at N+1 (PF_ISSUE); `rbuf` and incremented `addr` valid at N+3; `port_busy` high N+1..N+2 (PF_CAPTURE), low at N+3.
- Data write: `addr` incremented visible at N+1 + 1 edge (i.e. next access after one idle cycle sees new address); back-to-back data writes 1 cycle apart are legal.
- Minimum spacing between strobes: 1 cycle normally, 3 cycles after any read-ahead trigger.

## Test plan
- Reset, then control 0x34, 0x42 (code 1, addr 0x0234); data writes 0xAA, 0xBB -> `vram_we` at 0x0234=0xAA, 0x0235=0xBB.
- Control 0x05, 0x81 -> `reg_we` pulse, `reg_num`=1, `reg_data`=0x05; no VRAM/CRAM enable.
- Control 0x1F, 0xC0 then data 0x3F, 0x15 -> CRAM[0x1F]=0x3F, CRAM[0x00]=0x15 (wrap).
- Preload VRAM[0x0100]=0x11, [0x0101]=0x22; control 0x00, 0x01 (code 0); two data reads -> `cpu_dout` 0x11 then 0x22; `vram_re` at 0x0100, 0x0101, 0x0102.
- Control 0xFF, 0x7F (addr 0x3FFF, code 1), data writes -> VRAM[0x3FFF] then VRAM[0x0000].
- Control write 0x12, then control read with `status_in`=0x80 -> `cpu_dout`=0x80, `status_clr` pulse, `second` cleared (next control byte treated as first); strobe during `port_busy` produces no effect.
